// File: rtl/pd_pkg.sv
// Shared definitions for the pattern generator and the pattern detector.
package pd_pkg;

    typedef logic [1:0] pg_state_t;

    localparam pg_state_t S_IDLE = 2'd0;
    localparam pg_state_t S_PAT  = 2'd1;
    localparam pg_state_t S_GAP  = 2'd2;
    localparam pg_state_t S_DONE = 2'd3;

    localparam logic B = 1'b0;
    localparam logic C = 1'b1;

    localparam int PAT_LEN = 5;
    localparam logic [PAT_LEN-1:0] PAT_DEFAULT = 5'b00101;

endpackage

// File: rtl/pg_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) supplying pseudo-random filler bits.
module pg_lfsr #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic bit_o
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;
    logic       fb;

    assign fb     = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    assign lfsr_d = en_i ? {lfsr_q[6:0], fb} : lfsr_q;
    assign bit_o  = lfsr_q[7];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr_q <= SEED;
        else     lfsr_q <= lfsr_d;
    end

endmodule

// File: rtl/pattern_gen.sv
// Serial burst pattern transmitter; PG_LFSR_FILL_EN selects LFSR filler bits
// (with a 0,0 guard) instead of constant C filler.
module pattern_gen
    import pd_pkg::*;
#(
    parameter logic [PAT_LEN-1:0] PATTERN = PAT_DEFAULT
`ifdef PG_LFSR_FILL_EN
    ,
    parameter logic [7:0] LFSR_SEED = 8'hA5
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] burst_len,
    input  logic [3:0] gap,
    output logic       valid,
    output logic       dout,
    output logic       busy,
    output logic       done,
    output logic [7:0] pat_count
);

    pg_state_t  state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] gcnt_q, gcnt_d;
    logic [7:0] len_q, len_d;
    logic [3:0] gap_q, gap_d;
    logic [7:0] cnt_q, cnt_d;
    logic       valid_q, valid_d;
    logic       dout_q, dout_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       fill_bit;

`ifdef PG_LFSR_FILL_EN
    logic [1:0] hist_q, hist_d;
    logic       lfsr_bit;

    pg_lfsr #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .en_i (state_q == S_GAP),
        .bit_o(lfsr_bit)
    );

    // A 1 after two 0s would form a spurious 0,0,1 prefix inside the gap
    assign fill_bit = (hist_q == 2'b00) ? B : lfsr_bit;
    assign hist_d   = valid_d ? {hist_q[0], dout_d} : hist_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) hist_q <= 2'b11;
        else     hist_q <= hist_d;
    end
`else
    assign fill_bit = C;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        gcnt_d  = gcnt_q;
        len_d   = len_q;
        gap_d   = gap_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        dout_d  = 1'b0;
        busy_d  = (state_q != S_IDLE);
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // The cycle showing done is still IDLE but must not accept
                if (start && !done_q) begin
                    len_d   = burst_len;
                    gap_d   = gap;
                    cnt_d   = 8'd0;
                    idx_d   = 3'd0;
                    state_d = (burst_len == 8'd0) ? S_DONE : S_PAT;
                end
            end
            S_PAT: begin
                valid_d = 1'b1;
                dout_d  = PATTERN[3'(PAT_LEN - 1) - idx_q];
                if (idx_q == 3'(PAT_LEN - 1)) begin
                    cnt_d  = cnt_q + 8'd1;
                    idx_d  = 3'd0;
                    gcnt_d = 4'd0;
                    if (cnt_q + 8'd1 == len_q) state_d = S_DONE;
                    else if (gap_q != 4'd0)    state_d = S_GAP;
                    else                       state_d = S_PAT;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            S_GAP: begin
                valid_d = 1'b1;
                dout_d  = fill_bit;
                if (gcnt_q == gap_q - 4'd1) begin
                    idx_d   = 3'd0;
                    state_d = S_PAT;
                end else begin
                    gcnt_d = gcnt_q + 4'd1;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= 3'd0;
            gcnt_q  <= 4'd0;
            len_q   <= 8'd0;
            gap_q   <= 4'd0;
            cnt_q   <= 8'd0;
            valid_q <= 1'b0;
            dout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            gcnt_q  <= gcnt_d;
            len_q   <= len_d;
            gap_q   <= gap_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign valid     = valid_q;
    assign dout      = dout_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pat_count = cnt_q;

endmodule

// File: tb/tb_pattern_gen.sv
// Directed self-checking bench for pattern_gen with a 00101 sliding-window counter.
module tb_pattern_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] burst_len;
    logic [3:0] gap;
    logic       valid;
    logic       dout;
    logic       busy;
    logic       done;
    logic [7:0] pat_count;

    int compared   = 0;
    int mismatched = 0;

    bit stream[$];
    int vcnt;
    int done_at;
    int busy_cnt;
    int bad_idle;

    pattern_gen dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .burst_len(burst_len),
        .gap      (gap),
        .valid    (valid),
        .dout     (dout),
        .busy     (busy),
        .done     (done),
        .pat_count(pat_count)
    );

    always #5 clk = ~clk;

    function automatic int count_pat();
        logic [4:0] w = 5'b0;
        int cnt = 0;
        for (int i = 0; i < stream.size(); i++) begin
            w = {w[3:0], stream[i]};
            if (i >= 4 && w == 5'b00101) cnt++;
        end
        return cnt;
    endfunction

    function automatic logic [31:0] pack();
        logic [31:0] v = 32'b0;
        for (int i = 0; i < stream.size(); i++) v = {v[30:0], stream[i]};
        return v;
    endfunction

    task automatic run_burst(input logic [7:0] n, input logic [3:0] g,
                             input int limit);
        stream.delete();
        vcnt = 0; done_at = 0; busy_cnt = 0; bad_idle = 0;
        @(negedge clk);
        burst_len = n; gap = g; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (valid) begin stream.push_back(dout); vcnt++; end
            else if (dout) bad_idle++;
            if (done) begin done_at = c; break; end
        end
        compared++;
        if (done_at == 0) begin
            mismatched++;
            $display("FAIL timeout: done=0 after %0d cycles, required 1", limit);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; burst_len = 8'd0; gap = 4'd0;
        repeat (2) @(negedge clk);
        compared++; if (valid !== 1'b0) begin mismatched++; $display("FAIL rst_valid: got %b need 0", valid); end
        compared++; if (dout !== 1'b0) begin mismatched++; $display("FAIL rst_dout: got %b need 0", dout); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rst_busy: got %b need 0", busy); end
        compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL rst_done: got %b need 0", done); end
        compared++; if (pat_count !== 8'd0) begin mismatched++; $display("FAIL rst_count: got %0d need 0", pat_count); end
        rst = 1'b0;
        @(negedge clk);
        compared++; if ({valid, busy, done} !== 3'b000) begin mismatched++; $display("FAIL post_rst_idle: got %b need 000", {valid, busy, done}); end
    endtask

    task automatic test_single();
        run_burst(8'd1, 4'd3, 50);
        compared++; if (vcnt !== 5) begin mismatched++; $display("FAIL single_vcnt: got %0d need 5", vcnt); end
        compared++; if (pack() !== 32'b00101) begin mismatched++; $display("FAIL single_bits: got %b need 00101", pack()); end
        compared++; if (done_at !== 6) begin mismatched++; $display("FAIL single_done_at: got %0d need 6", done_at); end
        compared++; if (pat_count !== 8'd1) begin mismatched++; $display("FAIL single_count: got %0d need 1", pat_count); end
        compared++; if (count_pat() !== 1) begin mismatched++; $display("FAIL single_det: got %0d need 1", count_pat()); end
        compared++; if (busy_cnt !== 6) begin mismatched++; $display("FAIL single_busy: got %0d need 6", busy_cnt); end
        compared++; if (bad_idle !== 0) begin mismatched++; $display("FAIL single_idle_dout: got %0d need 0", bad_idle); end
        @(negedge clk);
        compared++; if ({busy, done} !== 2'b00) begin mismatched++; $display("FAIL single_end: got %b need 00", {busy, done}); end
        compared++; if (pat_count !== 8'd1) begin mismatched++; $display("FAIL single_hold: got %0d need 1", pat_count); end
    endtask

    task automatic test_back_to_back();
        run_burst(8'd3, 4'd0, 80);
        compared++; if (vcnt !== 15) begin mismatched++; $display("FAIL b2b_vcnt: got %0d need 15", vcnt); end
        compared++; if (pack() !== 32'b001010010100101) begin mismatched++; $display("FAIL b2b_bits: got %b need 001010010100101", pack()); end
        compared++; if (done_at !== 16) begin mismatched++; $display("FAIL b2b_done_at: got %0d need 16", done_at); end
        compared++; if (pat_count !== 8'd3) begin mismatched++; $display("FAIL b2b_count: got %0d need 3", pat_count); end
        compared++; if (count_pat() !== 3) begin mismatched++; $display("FAIL b2b_det: got %0d need 3", count_pat()); end
    endtask

`ifndef PG_LFSR_FILL_EN
    task automatic test_gap_fill();
        run_burst(8'd4, 4'd2, 100);
        compared++; if (vcnt !== 26) begin mismatched++; $display("FAIL gap_vcnt: got %0d need 26", vcnt); end
        compared++; if (pack() !== 32'b00101110010111001011100101) begin mismatched++; $display("FAIL gap_bits: got %b need 00101110010111001011100101", pack()); end
        compared++; if (done_at !== 27) begin mismatched++; $display("FAIL gap_done_at: got %0d need 27", done_at); end
        compared++; if (count_pat() !== 4) begin mismatched++; $display("FAIL gap_det: got %0d need 4", count_pat()); end
        compared++; if (pat_count !== 8'd4) begin mismatched++; $display("FAIL gap_count: got %0d need 4", pat_count); end
    endtask
`else
    task automatic test_lfsr_fill();
        int bad = 0;
        run_burst(8'd200, 4'd15, 5000);
        for (int i = 2; i < stream.size(); i++)
            if ((i % 20) >= 5 && stream[i] && !stream[i-1] && !stream[i-2]) bad++;
        compared++; if (vcnt !== 3985) begin mismatched++; $display("FAIL lfsr_vcnt: got %0d need 3985", vcnt); end
        compared++; if (count_pat() !== 200) begin mismatched++; $display("FAIL lfsr_det: got %0d need 200", count_pat()); end
        compared++; if (bad !== 0) begin mismatched++; $display("FAIL lfsr_gap_001: got %0d need 0", bad); end
        compared++; if (pat_count !== 8'd200) begin mismatched++; $display("FAIL lfsr_count: got %0d need 200", pat_count); end
    endtask
`endif

    task automatic test_zero_len();
        run_burst(8'd0, 4'd5, 20);
        compared++; if (vcnt !== 0) begin mismatched++; $display("FAIL zero_vcnt: got %0d need 0", vcnt); end
        compared++; if (done_at !== 1) begin mismatched++; $display("FAIL zero_done_at: got %0d need 1", done_at); end
        compared++; if (busy_cnt !== 1) begin mismatched++; $display("FAIL zero_busy: got %0d need 1", busy_cnt); end
        compared++; if (pat_count !== 8'd0) begin mismatched++; $display("FAIL zero_count: got %0d need 0", pat_count); end
        @(negedge clk);
        compared++; if ({busy, done} !== 2'b00) begin mismatched++; $display("FAIL zero_end: got %b need 00", {busy, done}); end
    endtask

    task automatic test_start_on_done();
        int more = 0;
        int seen = 0;
        run_burst(8'd1, 4'd0, 50);
        burst_len = 8'd2; gap = 4'd0; start = 1'b1;
        @(negedge clk);
        compared++; if ({busy, valid} !== 2'b00) begin mismatched++; $display("FAIL sod_ignored: got %b need 00", {busy, valid}); end
        @(negedge clk);
        start = 1'b0;
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL sod_accept_edge: busy got %b need 0", busy); end
        @(negedge clk);
        compared++; if ({valid, busy, dout} !== 3'b110) begin mismatched++; $display("FAIL sod_first_bit: got %b need 110", {valid, busy, dout}); end
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (valid) more++;
            if (done) begin seen = 1; break; end
        end
        compared++; if (seen !== 1) begin mismatched++; $display("FAIL sod_timeout: done=0 after 50 cycles, required 1"); end
        compared++; if (more !== 9) begin mismatched++; $display("FAIL sod_vcnt: got %0d need 9", more); end
        compared++; if (pat_count !== 8'd2) begin mismatched++; $display("FAIL sod_count: got %0d need 2", pat_count); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        stream.delete();
        @(negedge clk);
        burst_len = 8'd4; gap = 4'd0; start = 1'b1;
        @(negedge clk);
        burst_len = 8'd9; gap = 4'd7;
        for (int c = 0; c < 40 && stream.size() < 7; c++) begin
            @(negedge clk);
            if (valid) stream.push_back(dout);
        end
        compared++; if (pack() !== 32'b0010100) begin mismatched++; $display("FAIL mid_bits: got %b need 0010100", pack()); end
        compared++; if (pat_count !== 8'd1) begin mismatched++; $display("FAIL mid_count: got %0d need 1", pat_count); end
        rst = 1'b1;
        #1;
        compared++; if ({valid, busy, done, dout} !== 4'b0000) begin mismatched++; $display("FAIL mid_rst_flags: got %b need 0000", {valid, busy, done, dout}); end
        compared++; if (pat_count !== 8'd0) begin mismatched++; $display("FAIL mid_rst_count: got %0d need 0", pat_count); end
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        compared++; if ({valid, busy} !== 2'b00) begin mismatched++; $display("FAIL mid_after: got %b need 00", {valid, busy}); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
`ifndef PG_LFSR_FILL_EN
        test_gap_fill();
`else
        test_lfsr_fill();
`endif
        test_zero_len();
        test_start_on_done();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
